zigzag_reorder: RTL and testbench

Double-buffered 8x8 coefficient reorder stage directly downstream of the JPEG coder's quantised-DCT output, one instance per colour component. It accepts 64 signed coefficients per block in raster order (row-major, index = 8*row + col) and emits them in JPEG zigzag order. The entropy/run-length coder consumes its output. Two 64-entry banks ping-pong, so one block can be written while the previous block is read, sustaining one coefficient per cycle.

---
 rtl/zigzag_reorder_if.sv | 34 +++
 rtl/zigzag_reorder.sv | 125 ++++++++++++
 tb/tb_zigzag_reorder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zigzag_reorder_if.sv
// Coefficient stream bundle: raster-order input side and zigzag-order output side.
// out_eob exists only when ZIGZAG_EOB_EN is defined.
interface zigzag_reorder_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;
`ifdef ZIGZAG_EOB_EN
    logic                  out_eob;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_eob
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_eob
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
`endif
endinterface

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 raster-to-zigzag coefficient reorder, 1 coefficient/cycle; ZIGZAG_EOB_EN adds out_eob.
// Latency: first out_valid one edge after the block's 64th input is accepted.
// Backpressure: in_ready low only while both banks are FULL; output register holds while out_ready low.
module zigzag_reorder #(
    parameter int DATA_WIDTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    zigzag_reorder_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_st_t;

    // zigzag index -> raster address
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DATA_WIDTH-1:0] mem [2][64];
    bank_st_t              st_q [2];
    bank_st_t              st_d [2];
    logic                  wsel, rsel;
    logic [5:0]            wp, rp;
    logic                  wr, load;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  out_valid_q, out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    assign bus.in_ready  = !rst && (st_q[wsel] == EMPTY);
    assign wr            = bus.in_valid && bus.in_ready;
    assign load          = (st_q[rsel] == FULL) && (!out_valid_q || bus.out_ready);
    assign rd_data       = mem[rsel][ZZ[rp]];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    // A write needs an EMPTY bank and a load a FULL one, so both edits never hit the same bank.
    always_comb begin
        st_d = st_q;
        if (wr && wp == 6'd63)
            st_d[wsel] = FULL;
        if (load && rp == 6'd63)
            st_d[rsel] = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0] <= EMPTY;
            st_q[1] <= EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wsel][wp] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp          <= 6'd0;
            rp          <= 6'd0;
            wsel        <= 1'b0;
            rsel        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (wr) begin
                wp <= wp + 6'd1;
                if (wp == 6'd63)
                    wsel <= ~wsel;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rd_data;
                out_last_q  <= (rp == 6'd63);
                rp          <= rp + 6'd1;
                if (rp == 6'd63)
                    rsel <= ~rsel;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ZIGZAG_EOB_EN
    logic [5:0] lastnz [2];
    logic       out_eob_q;

    function automatic logic [5:0] izz(input logic [5:0] raster);
        izz = 6'd0;
        for (int i = 0; i < 64; i++)
            if (ZZ[i] == raster)
                izz = 6'(i);
    endfunction

    assign bus.out_eob = out_eob_q;

    // Track the highest zigzag index holding a nonzero coefficient; 0 for an all-zero block.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastnz[0] <= 6'd0;
            lastnz[1] <= 6'd0;
            out_eob_q <= 1'b0;
        end else begin
            if (wr) begin
                if (wp == 6'd0)
                    lastnz[wsel] <= 6'd0;
                else if (bus.in_data != '0 && izz(wp) > lastnz[wsel])
                    lastnz[wsel] <= izz(wp);
            end
            if (load)
                out_eob_q <= (rp == lastnz[rsel]);
        end
    end
`endif
endmodule

// File: tb/tb_zigzag_reorder.sv
// Directed bench for zigzag_reorder: reset, ramp, streaming, backpressure, random stall, mid-block reset, EOB.
module tb_zigzag_reorder;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk = 0;
    int   pass = 0;
    int   cyc = 0;
    int   timeouts = 0;
    bit   done_r;

    zigzag_reorder_if #(.DATA_WIDTH(DW)) bus ();
    zigzag_reorder #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int zz_tab [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          eob;
        int            cyc;
    } obs_t;
    obs_t oq [$];
    obs_t mon_o;

    // Record each output transfer on the negedge preceding the edge that completes it.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            mon_o.d    = bus.out_data;
            mon_o.last = bus.out_last;
`ifdef ZIGZAG_EOB_EN
            mon_o.eob  = bus.out_eob;
`else
            mon_o.eob  = 1'b0;
`endif
            mon_o.cyc  = cyc;
            oq.push_back(mon_o);
        end
    end

    task automatic put_word(input logic [DW-1:0] d, output int stalls, output int acc_cyc);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        stalls       = 0;
        acc_cyc      = -1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_cyc = cyc + 1;
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        timeouts++;
    endtask

    task automatic wait_outputs(input int n, input int bound);
        for (int t = 0; t < bound; t++) begin
            if (oq.size() >= n) break;
            @(posedge clk);
        end
        if (oq.size() < n) timeouts++;
        #1;
    endtask

    function automatic logic [DW-1:0] v_b2b(input int b, input int r);
        return DW'((b * 64 + r) * 7 + 1);
    endfunction

    function automatic logic [DW-1:0] v_bp(input int i);
        return DW'(i * 3 + 5);
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else pass++;
        chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass++;
        chk++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data); else pass++;
        chk++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", bus.out_last); else pass++;
`ifdef ZIGZAG_EOB_EN
        chk++; if (bus.out_eob !== 1'b0) $display("FAIL reset_out_eob: got %b want 0", bus.out_eob); else pass++;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); else pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int st, ac, last_acc;
        oq.delete(); timeouts = 0; bus.out_ready = 1'b1; last_acc = 0;
        for (int i = 0; i < 64; i++) begin
            put_word(DW'(i), st, ac);
            last_acc = ac;
        end
        bus.in_valid = 1'b0;
        wait_outputs(64, 300);
        chk++; if (timeouts !== 0) $display("FAIL ramp_timeout: got %0d want 0", timeouts); else pass++;
        chk++; if (oq.size() !== 64) $display("FAIL ramp_count: got %0d want 64", oq.size()); else pass++;
        if (oq.size() == 64) begin
            chk++; if (oq[0].cyc - last_acc !== 1) $display("FAIL ramp_latency: got %0d want 1", oq[0].cyc - last_acc); else pass++;
            for (int k = 0; k < 64; k++) begin
                chk++; if (oq[k].d !== DW'(zz_tab[k])) $display("FAIL ramp_data[%0d]: got %0d want %0d", k, oq[k].d, zz_tab[k]); else pass++;
                chk++; if (oq[k].last !== (k == 63)) $display("FAIL ramp_last[%0d]: got %b want %b", k, oq[k].last, (k == 63)); else pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int st, ac, stall_tot, gaps;
        oq.delete(); timeouts = 0; bus.out_ready = 1'b1; stall_tot = 0; gaps = 0;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 64; i++) begin
                put_word(v_b2b(b, i), st, ac);
                stall_tot += st;
            end
        bus.in_valid = 1'b0;
        wait_outputs(256, 600);
        chk++; if (timeouts !== 0) $display("FAIL b2b_timeout: got %0d want 0", timeouts); else pass++;
        chk++; if (stall_tot !== 0) $display("FAIL b2b_in_stalls: got %0d want 0", stall_tot); else pass++;
        chk++; if (oq.size() !== 256) $display("FAIL b2b_count: got %0d want 256", oq.size()); else pass++;
        if (oq.size() == 256) begin
            for (int k = 0; k < 256; k++) begin
                if (oq[k].cyc != oq[0].cyc + k) gaps++;
                chk++; if (oq[k].d !== v_b2b(k / 64, zz_tab[k % 64])) $display("FAIL b2b_data[%0d]: got %0d want %0d", k, oq[k].d, v_b2b(k / 64, zz_tab[k % 64])); else pass++;
            end
            chk++; if (gaps !== 0) $display("FAIL b2b_consecutive: got %0d gaps want 0", gaps); else pass++;
        end
    endtask

    task automatic test_backpressure();
        int st, ac, stall_tot, cnt;
        bit seen;
        oq.delete(); timeouts = 0; bus.out_ready = 1'b0; stall_tot = 0; cnt = 0; seen = 1'b0;
        for (int i = 0; i < 128; i++) begin
            put_word(v_bp(i), st, ac);
            stall_tot += st;
        end
        bus.in_valid = 1'b0;
        chk++; if (stall_tot !== 0) $display("FAIL bp_fill_stalls: got %0d want 0", stall_tot); else pass++;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low[%0d]: got %b want 0", t, bus.in_ready); else pass++;
            chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== v_bp(0)) $display("FAIL bp_hold[%0d]: got v=%b d=%0d want v=1 d=%0d", t, bus.out_valid, bus.out_data, v_bp(0)); else pass++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        // in_ready must come back exactly as the 64th load (index 63) lands: 63 transfers precede it.
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin seen = 1'b1; break; end
            if (bus.out_valid && bus.out_ready) cnt++;
        end
        chk++; if (!seen || cnt !== 63) $display("FAIL bp_release: got seen=%b transfers=%0d want seen=1 transfers=63", seen, cnt); else pass++;
        wait_outputs(128, 400);
        repeat (10) @(posedge clk);
        #1;
        chk++; if (timeouts !== 0) $display("FAIL bp_timeout: got %0d want 0", timeouts); else pass++;
        chk++; if (oq.size() !== 128) $display("FAIL bp_count: got %0d want 128", oq.size()); else pass++;
        if (oq.size() == 128)
            for (int k = 0; k < 128; k++) begin
                chk++; if (oq[k].d !== v_bp((k / 64) * 64 + zz_tab[k % 64])) $display("FAIL bp_data[%0d]: got %0d want %0d", k, oq[k].d, v_bp((k / 64) * 64 + zz_tab[k % 64])); else pass++;
            end
    endtask

    task automatic test_random();
        logic [DW-1:0] rnd [640];
        int st, ac;
        oq.delete(); timeouts = 0; done_r = 1'b0;
        for (int i = 0; i < 640; i++) rnd[i] = DW'($urandom_range(0, 4095));
        fork
            begin
                for (int i = 0; i < 640; i++) put_word(rnd[i], st, ac);
                bus.in_valid = 1'b0;
                done_r = 1'b1;
            end
            begin
                for (int t = 0; t < 20000; t++) begin
                    if (done_r && oq.size() >= 640) break;
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk++; if (timeouts !== 0 || !done_r) $display("FAIL rand_timeout: got %0d done=%b want 0 done=1", timeouts, done_r); else pass++;
        chk++; if (oq.size() !== 640) $display("FAIL rand_count: got %0d want 640", oq.size()); else pass++;
        if (oq.size() == 640)
            for (int k = 0; k < 640; k++) begin
                chk++; if (oq[k].d !== rnd[(k / 64) * 64 + zz_tab[k % 64]] || oq[k].last !== (k % 64 == 63))
                    $display("FAIL rand_out[%0d]: got d=%0d last=%b want d=%0d last=%b", k, oq[k].d, oq[k].last, rnd[(k / 64) * 64 + zz_tab[k % 64]], (k % 64 == 63));
                else pass++;
            end
    endtask

    task automatic test_reset_mid();
        int st, ac;
        timeouts = 0; bus.out_ready = 1'b1;
        for (int i = 0; i < 30; i++) put_word(DW'(100 + i), st, ac);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        oq.delete();
        for (int i = 0; i < 64; i++) put_word(DW'(2000 + i), st, ac);
        bus.in_valid = 1'b0;
        wait_outputs(64, 300);
        repeat (80) @(posedge clk);
        #1;
        chk++; if (timeouts !== 0) $display("FAIL rmid_timeout: got %0d want 0", timeouts); else pass++;
        chk++; if (oq.size() !== 64) $display("FAIL rmid_count: got %0d want 64", oq.size()); else pass++;
        if (oq.size() == 64)
            for (int k = 0; k < 64; k++) begin
                chk++; if (oq[k].d !== DW'(2000 + zz_tab[k]) || oq[k].last !== (k == 63))
                    $display("FAIL rmid_out[%0d]: got d=%0d last=%b want d=%0d last=%b", k, oq[k].d, oq[k].last, 2000 + zz_tab[k], (k == 63));
                else pass++;
            end
    endtask

`ifdef ZIGZAG_EOB_EN
    task automatic test_eob();
        int st, ac;
        logic [DW-1:0] d;
        oq.delete(); timeouts = 0; bus.out_ready = 1'b1;
        // Block A nonzero at raster 0 and 9 (zigzag 4); block B all zero.
        for (int i = 0; i < 64; i++) begin
            d = (i == 0) ? DW'(5) : (i == 9) ? DW'(-3) : '0;
            put_word(d, st, ac);
        end
        for (int i = 0; i < 64; i++) put_word('0, st, ac);
        bus.in_valid = 1'b0;
        wait_outputs(128, 400);
        chk++; if (timeouts !== 0) $display("FAIL eob_timeout: got %0d want 0", timeouts); else pass++;
        chk++; if (oq.size() !== 128) $display("FAIL eob_count: got %0d want 128", oq.size()); else pass++;
        if (oq.size() == 128)
            for (int k = 0; k < 128; k++) begin
                chk++; if (oq[k].eob !== (k == 4 || k == 64)) $display("FAIL eob_flag[%0d]: got %b want %b", k, oq[k].eob, (k == 4 || k == 64)); else pass++;
            end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass, chk);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef ZIGZAG_EOB_EN
        test_eob();
`endif
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
